led_mode_sequencer: RTL
=======================

// Module: led_mode_sequencer
// PURPOSE
//  Top-level LED display controller for the board's 6 active-low LEDs. Debounces the
//  active-low user button, decodes short/long presses, and sequences one of four
//  LED patterns at a selectable step rate from a shared prescaler.
//  Short press selects the pattern mode; long press selects the speed.
// PARAMETERS
//  DEBOUNCE_CYCLES    270000    consecutive stable samples needed to accept a button level (10 ms @ 27 MHz)
//  LONG_PRESS_CYCLES  13500000  hold time, in cycles, that turns a press into a long press (0.5 s)
//  TICK_BASE          13500000  step period in cycles at speed 0; must be < 2^24 and >= 16
//  DIM_DUTY           64        PWM on-count out of 256; used only with LED_PWM_DIM_EN
// PORTS
//  clk        in   1  system clock, 27 MHz
//  rst        in   1  synchronous reset, active-high
//  btn1       in   1  raw user button, active-low, asynchronous to clk
//  led        out  6  LED drive, active-low (0 = lit)
//  mode       out  2  current pattern mode
//  speed      out  2  current speed setting
//  step_tick  out  1  one-cycle pulse on each pattern step
// BEHAVIOUR
//  Reset: led=6'b111111, mode=0, speed=0, step_tick=0, prescaler=0, pattern state cleared,
//   press FSM=IDLE, debounced level=released. A button held through reset counts as a new press.
//  Input path: 2-FF synchroniser, then debounce. Accept a new level only after DEBOUNCE_CYCLES
//   consecutive equal samples. Any differing sample restarts the count.
//  Press FSM:
//   IDLE     -> PRESSED when the debounced press is accepted. Clear the hold counter.
//   PRESSED  -> IDLE on release before LONG_PRESS_CYCLES. Emit one short event.
//   PRESSED  -> LONG_HELD when the hold counter reaches LONG_PRESS_CYCLES. Emit one long event.
//   LONG_HELD-> IDLE on release. Emit no event.
//  Short event: mode <= mode+1, wrapping 3->0. Reset pattern state and prescaler in the same cycle.
//  Long event: speed <= speed+1, wrapping 3->0. Clear the prescaler. Pattern state is kept.
//  Prescaler: period P = TICK_BASE >> speed. Counts 0..P-1. step_tick=1 for exactly the
//   cycle in which count==P-1, then the count returns to 0.
//  Event and tick in the same cycle: the event wins and step_tick is suppressed.
//  Modes (pattern advances on step_tick; led = ~pattern, updated the cycle after step_tick):
//   0 BINARY: 6-bit count, increments and wraps 63->0. Entry value 0.
//   1 BOUNCE: one-hot position 0..5. Entry position 0, direction up. Sequence 0,1,..,5,4,..,0,1.
//      Direction flips at each end with no repeated position.
//   2 BLINK: pattern toggles between 6'h00 and 6'h3F. Entry value 6'h00.
//   3 FILL: n lit = 0..6, pattern=(1<<n)-1, wraps 6->0. Entry n=0.
//  Entering a mode shows its entry pattern on led one cycle after the short event.
//  mode and speed outputs are registered and change one cycle after the event.
// CONFIGURATION
//  LED_PWM_DIM_EN defined:
//   - An 8-bit free-running PWM counter is added.
//   - led is registered as ~(pattern & {6{pwm_cnt < DIM_DUTY}}).
//   - Lit LEDs run at DIM_DUTY/256 duty. The counter resets to 0.
//  LED_PWM_DIM_EN undefined:
//   - No PWM logic is built; led = ~pattern, static between steps.
//   - DIM_DUTY is ignored.
// TESTING (bench params: DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, TICK_BASE=16)
//  1 Release rst, btn1 high -> led=6'h3F; step_tick every 16 cycles; after 3 ticks led=6'b111100.
//  2 btn1 low 10 cycles, then high -> exactly one mode change, 0->1; led=6'b111110;
//     next ticks show lit LED 1,2,3,4,5,4 (led=6'b111101, ...).
//  3 btn1 low pulses of 3 cycles, repeated -> mode and speed never change.
//  4 btn1 low 40 cycles -> speed=1 once, mode unchanged, tick period 8;
//     4 long presses wrap speed back to 0 (period 16).
//  5 Mode 0: 64 ticks -> led returns to 6'h3F. Mode 3: ticks give lit counts 0..6, then 0.
//  6 rst=1 for one cycle mid-BOUNCE at speed 2 -> next cycle led=6'h3F, mode=0, speed=0, step_tick=0.
//  7 With LED_PWM_DIM_EN, DIM_DUTY=64, mode 2 lit phase -> led=6'h00 for 64 of every 256 cycles.

Source files
------------

// File: rtl/led_mode_sequencer_if.sv
// Board-side bundle for led_mode_sequencer: raw button in, LED drive and status out.
interface led_mode_sequencer_if;
   logic       btn1;
   logic [5:0] led;
   logic [1:0] mode;
   logic [1:0] speed;
   logic       step_tick;

   modport master (output btn1, input led, mode, speed, step_tick);
   modport slave  (input btn1, output led, mode, speed, step_tick);
endinterface

// File: rtl/led_mode_sequencer.sv
// LED pattern sequencer: debounced button, short/long press decode, four patterns, prescaled steps.
// Optional LED_PWM_DIM_EN adds an 8-bit PWM dimmer on the LED drive.
module led_mode_sequencer #(
   parameter int DEBOUNCE_CYCLES   = 270000,
   parameter int LONG_PRESS_CYCLES = 13500000,
   parameter int TICK_BASE         = 13500000,
   parameter int DIM_DUTY          = 64
) (
   input  logic                clk,
   input  logic                rst,
   led_mode_sequencer_if.slave io
);
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_PRESSED = 2'd1;
   localparam logic [1:0] S_LONG    = 2'd2;

   logic            sync1_q, sync2_q;
   logic            db_q, db_d;
   logic [DB_W-1:0] dbc_q, dbc_d;
   logic [1:0]      st_q, st_d;
   logic [LP_W-1:0] hold_q, hold_d;
   logic            short_ev, long_ev, any_ev;
   logic [1:0]      mode_q, mode_d;
   logic [1:0]      speed_q, speed_d;
   logic [23:0]     pre_q, pre_d, period;
   logic            tick_raw, step_tick;
   logic [5:0]      pat_q, pat_d;
   logic            dir_q, dir_d;

   // Raw step state -> displayed pattern; s is count, position, phase or fill level by mode.
   function automatic logic [5:0] pat_of(input logic [1:0] m, input logic [5:0] s);
      logic [6:0] f;
      f = (7'd1 << s[2:0]) - 7'd1;
      case (m)
         2'd0:    pat_of = s;
         2'd1:    pat_of = 6'd1 << s[2:0];
         2'd2:    pat_of = {6{s[0]}};
         default: pat_of = f[5:0];
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= io.btn1;
         sync2_q <= sync1_q;
      end
   end

   // Counts consecutive samples that disagree with the accepted level.
   always_comb begin
      db_d  = db_q;
      dbc_d = '0;
      if (sync2_q != db_q) begin
         if (dbc_q == DB_W'(DEBOUNCE_CYCLES - 1)) db_d = sync2_q;
         else                                    dbc_d = dbc_q + 1'b1;
      end
   end

   always_comb begin
      st_d     = st_q;
      hold_d   = hold_q;
      short_ev = 1'b0;
      long_ev  = 1'b0;
      case (st_q)
         S_IDLE: begin
            if (!db_q) begin
               st_d   = S_PRESSED;
               hold_d = '0;
            end
         end
         S_PRESSED: begin
            if (db_q) begin
               st_d     = S_IDLE;
               short_ev = 1'b1;
            end else if (hold_q == LP_W'(LONG_PRESS_CYCLES - 1)) begin
               st_d    = S_LONG;
               long_ev = 1'b1;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         S_LONG:  if (db_q) st_d = S_IDLE;
         default: st_d = S_IDLE;
      endcase
   end

   assign any_ev  = short_ev | long_ev;
   assign mode_d  = mode_q + {1'b0, short_ev};
   assign speed_d = speed_q + {1'b0, long_ev};

   // An event restarts the step period and swallows a coincident tick.
   assign period    = 24'(TICK_BASE) >> speed_q;
   assign tick_raw  = (pre_q == period - 24'd1);
   assign step_tick = tick_raw & ~any_ev;
   assign pre_d     = (any_ev | tick_raw) ? 24'd0 : pre_q + 24'd1;

   always_comb begin
      pat_d = pat_q;
      dir_d = dir_q;
      if (short_ev) begin
         pat_d = '0;
         dir_d = 1'b0;
      end else if (step_tick) begin
         case (mode_q)
            2'd0: pat_d = pat_q + 6'd1;
            2'd1: begin
               if (!dir_q) begin
                  if (pat_q == 6'd5) begin
                     pat_d = 6'd4;
                     dir_d = 1'b1;
                  end else begin
                     pat_d = pat_q + 6'd1;
                  end
               end else begin
                  if (pat_q == 6'd0) begin
                     pat_d = 6'd1;
                     dir_d = 1'b0;
                  end else begin
                     pat_d = pat_q - 6'd1;
                  end
               end
            end
            2'd2:    pat_d = {5'd0, ~pat_q[0]};
            default: pat_d = (pat_q == 6'd6) ? 6'd0 : pat_q + 6'd1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         db_q    <= 1'b1;
         dbc_q   <= '0;
         st_q    <= S_IDLE;
         hold_q  <= '0;
         mode_q  <= 2'd0;
         speed_q <= 2'd0;
         pre_q   <= 24'd0;
         pat_q   <= 6'd0;
         dir_q   <= 1'b0;
      end else begin
         db_q    <= db_d;
         dbc_q   <= dbc_d;
         st_q    <= st_d;
         hold_q  <= hold_d;
         mode_q  <= mode_d;
         speed_q <= speed_d;
         pre_q   <= pre_d;
         pat_q   <= pat_d;
         dir_q   <= dir_d;
      end
   end

`ifdef LED_PWM_DIM_EN
   logic [7:0] pwm_q;
   logic [5:0] led_q;

   // Registered from next-state so step latency matches the undimmed build.
   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_q <= 8'd0;
         led_q <= 6'h3F;
      end else begin
         pwm_q <= pwm_q + 8'd1;
         led_q <= ~(pat_of(mode_d, pat_d) & {6{{1'b0, pwm_q} < 9'(DIM_DUTY)}});
      end
   end

   assign io.led = led_q;
`else
   assign io.led = ~pat_of(mode_q, pat_q);
`endif

   assign io.mode      = mode_q;
   assign io.speed     = speed_q;
   assign io.step_tick = step_tick;
endmodule
